// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole game controller.
//   state_e    : game state machine encoding (idle / play / over)
//   evt_cnt_t  : wide-enough count type for per-cycle event tallies
//   cnt_w()    : width of a counter that must hold 0 .. n-1 (never zero)
package whack_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StOver
  } state_e;

  // Holds any mole population up to 255 channels.
  localparam int unsigned EvtCntW = 8;
  typedef logic [EvtCntW-1:0] evt_cnt_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mole_slot.sv
// One mole channel: active flag plus lifetime counter.
// Ports:
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   spawn_i      light this mole (only asserted while it is dark)
//   whack_i      switch edge for this mole, already gated to the play state
//   clear_all_i  darken silently (restart / game end); suppresses events
//   active_o     mole lit (registered)
//   hit_o        this cycle's whack lands on a lit mole
//   expire_o     this cycle the lit mole reaches the end of its life unhit
module mole_slot
  import whack_pkg::*;
#(
  parameter int unsigned LIFE_TICKS = 100000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spawn_i,
  input  logic whack_i,
  input  logic clear_all_i,
  output logic active_o,
  output logic hit_o,
  output logic expire_o
);

  localparam int unsigned LifeW = cnt_w(LIFE_TICKS);
  localparam logic [LifeW-1:0] LifeMax = LifeW'(LIFE_TICKS - 1);

  logic             active_q, active_d;
  logic [LifeW-1:0] life_q, life_d;

  always_comb begin
    hit_o    = active_q & whack_i & ~clear_all_i;
    // A hit in the expiry cycle wins, so no miss is reported.
    expire_o = active_q & ~whack_i & ~clear_all_i & (life_q == LifeMax);

    active_d = active_q;
    life_d   = life_q;
    if (clear_all_i || hit_o || expire_o) begin
      active_d = 1'b0;
      life_d   = '0;
    end else if (spawn_i) begin
      active_d = 1'b1;
      life_d   = '0;
    end else if (active_q) begin
      life_d = life_q + LifeW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      life_q   <= '0;
    end else begin
      active_q <= active_d;
      life_q   <= life_d;
    end
  end

  assign active_o = active_q;

endmodule

// File: rtl/whack_controller.sv
// Game controller for the switch/LED whack-a-mole game.
// Runs an idle/play/over state machine with a seconds countdown, attempts a
// mole spawn every SPAWN_TICKS clocks using the random index, caps the number
// of lit moles at MAX_ACTIVE, and reports per-cycle hit and miss counts.
// Ports:
//   CLOCK_50    system clock
//   rst         synchronous, active-high reset
//   start       one-cycle pulse; starts or restarts a game
//   rand_value  free-running random mole index
//   edge_in     one-cycle switch edge pulses, one per mole
//   moles       lit moles (to LEDR)
//   hit_pulse   at least one hit last cycle
//   miss_pulse  at least one miss last cycle
//   hit_num     number of hits last cycle
//   miss_num    number of misses last cycle
//   time_left   seconds remaining
//   playing     game in progress
//   game_over   game finished, waiting for start
// Build option: define WHACK_PENALTY_EN to count edges on dark moles during
// play as misses.
module whack_controller
  import whack_pkg::*;
#(
  parameter int unsigned NUM_MOLES     = 18,
  parameter int unsigned IDX_W         = 5,
  parameter int unsigned SPAWN_TICKS   = 50000000,
  parameter int unsigned LIFE_TICKS    = 100000000,
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned GAME_SECONDS  = 60,
  parameter int unsigned MAX_ACTIVE    = 4
) (
  input  logic                             CLOCK_50,
  input  logic                             rst,
  input  logic                             start,
  input  logic [IDX_W-1:0]                 rand_value,
  input  logic [NUM_MOLES-1:0]             edge_in,
  output logic [NUM_MOLES-1:0]             moles,
  output logic                             hit_pulse,
  output logic                             miss_pulse,
  output logic [$clog2(NUM_MOLES+1)-1:0]   hit_num,
  output logic [$clog2(NUM_MOLES+1)-1:0]   miss_num,
  output logic [6:0]                       time_left,
  output logic                             playing,
  output logic                             game_over
);

  localparam int unsigned NumW   = $clog2(NUM_MOLES + 1);
  localparam int unsigned SpawnW = cnt_w(SPAWN_TICKS);
  localparam int unsigned SecW   = cnt_w(TICKS_PER_SEC);
  localparam logic [SpawnW-1:0] SpawnMax = SpawnW'(SPAWN_TICKS - 1);
  localparam logic [SecW-1:0]   SecMax   = SecW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]        GameSecs = 7'(GAME_SECONDS);

  state_e              state_q, state_d;
  logic [6:0]          time_left_q, time_left_d;
  logic [SpawnW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [SecW-1:0]     sec_cnt_q, sec_cnt_d;
  logic [NumW-1:0]     hit_num_q, hit_num_d;
  logic [NumW-1:0]     miss_num_q, miss_num_d;
  logic                hit_pulse_q, miss_pulse_q;

  logic                clear_all;
  logic                spawn_try;
  logic                spawn_ok;
  logic [NUM_MOLES-1:0] active;
  logic [NUM_MOLES-1:0] hit_vec;
  logic [NUM_MOLES-1:0] expire_vec;
  logic [NUM_MOLES-1:0] match_vec;
  logic [NUM_MOLES-1:0] spawn_vec;
  logic [NUM_MOLES-1:0] whack_vec;
  logic [NUM_MOLES-1:0] penalty_vec;
  evt_cnt_t            active_cnt;

  function automatic evt_cnt_t popcount(input logic [NUM_MOLES-1:0] v);
    evt_cnt_t c;
    c = '0;
    for (int unsigned j = 0; j < NUM_MOLES; j++) begin
      c = c + evt_cnt_t'(v[j]);
    end
    return c;
  endfunction

  // Game state machine and timers.
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    spawn_cnt_d = spawn_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    clear_all   = 1'b0;
    spawn_try   = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d     = StPlay;
          time_left_d = GameSecs;
          spawn_cnt_d = '0;
          sec_cnt_d   = '0;
        end
      end
      StPlay: begin
        if (start) begin
          // Restart: drop every mole without charging misses.
          clear_all   = 1'b1;
          time_left_d = GameSecs;
          spawn_cnt_d = '0;
          sec_cnt_d   = '0;
        end else if (sec_cnt_q == SecMax && time_left_q <= 7'd1) begin
          state_d     = StOver;
          clear_all   = 1'b1;
          time_left_d = '0;
          spawn_cnt_d = '0;
          sec_cnt_d   = '0;
        end else begin
          spawn_try   = (spawn_cnt_q == SpawnMax);
          spawn_cnt_d = spawn_try ? '0 : spawn_cnt_q + SpawnW'(1);
          if (sec_cnt_q == SecMax) begin
            sec_cnt_d   = '0;
            time_left_d = time_left_q - 7'd1;
          end else begin
            sec_cnt_d = sec_cnt_q + SecW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Spawn arbitration: all checks use the mole state at the start of the cycle.
  always_comb begin
    for (int unsigned j = 0; j < NUM_MOLES; j++) begin
      match_vec[j] = (32'(rand_value) == j);
    end
    active_cnt = popcount(active);
    // An out-of-range index leaves match_vec empty, which skips the attempt.
    spawn_ok   = spawn_try && (|match_vec) && !(|(match_vec & active)) &&
                 (32'(active_cnt) < MAX_ACTIVE);
    spawn_vec  = spawn_ok ? match_vec : '0;
    whack_vec  = (state_q == StPlay) ? edge_in : '0;
  end

`ifdef WHACK_PENALTY_EN
  // Edges on dark moles during play cost a miss.
  assign penalty_vec = (state_q == StPlay && !clear_all) ? (edge_in & ~active) : '0;
`else
  assign penalty_vec = '0;
`endif

  for (genvar g = 0; g < NUM_MOLES; g++) begin : g_slot
    mole_slot #(
      .LIFE_TICKS (LIFE_TICKS)
    ) u_slot (
      .clk_i       (CLOCK_50),
      .rst_i       (rst),
      .spawn_i     (spawn_vec[g]),
      .whack_i     (whack_vec[g]),
      .clear_all_i (clear_all),
      .active_o    (active[g]),
      .hit_o       (hit_vec[g]),
      .expire_o    (expire_vec[g])
    );
  end

  // Expiry needs a lit mole and a penalty needs a dark one, so OR-ing is exact.
  always_comb begin
    hit_num_d  = NumW'(popcount(hit_vec));
    miss_num_d = NumW'(popcount(expire_vec | penalty_vec));
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q      <= StIdle;
      time_left_q  <= GameSecs;
      spawn_cnt_q  <= '0;
      sec_cnt_q    <= '0;
      hit_num_q    <= '0;
      miss_num_q   <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      time_left_q  <= time_left_d;
      spawn_cnt_q  <= spawn_cnt_d;
      sec_cnt_q    <= sec_cnt_d;
      hit_num_q    <= hit_num_d;
      miss_num_q   <= miss_num_d;
      hit_pulse_q  <= (hit_num_d != '0);
      miss_pulse_q <= (miss_num_d != '0);
    end
  end

  assign moles      = active;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign hit_num    = hit_num_q;
  assign miss_num   = miss_num_q;
  assign time_left  = time_left_q;
  assign playing    = (state_q == StPlay);
  assign game_over  = (state_q == StOver);

endmodule

// File: tb/tb_whack_controller.sv
// Self-checking bench for whack_controller with small timing parameters.
// A behavioural game model tracks lit moles and their ages as plain arrays;
// every clock all outputs are compared against it, with directed checks at
// the interesting points followed by a randomized play phase.
module tb_whack_controller;

  localparam int NM  = 18;
  localparam int SP  = 10;
  localparam int LT  = 25;
  localparam int TPS = 20;
  localparam int GS  = 3;
  localparam int MA  = 2;

  localparam int MIdle = 0;
  localparam int MPlay = 1;
  localparam int MOver = 2;

  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    rand_value = '0;
  logic [NM-1:0] edge_in = '0;
  logic [NM-1:0] moles;
  logic          hit_pulse, miss_pulse;
  logic [4:0]    hit_num, miss_num;
  logic [6:0]    time_left;
  logic          playing, game_over;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state.
  int        m_state;
  bit [NM-1:0] m_act;
  int        m_age[NM];
  int        m_time, m_tick, m_sp, m_hit, m_miss;

  whack_controller #(
    .NUM_MOLES     (NM),
    .IDX_W         (5),
    .SPAWN_TICKS   (SP),
    .LIFE_TICKS    (LT),
    .TICKS_PER_SEC (TPS),
    .GAME_SECONDS  (GS),
    .MAX_ACTIVE    (MA)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .start      (start),
    .rand_value (rand_value),
    .edge_in    (edge_in),
    .moles      (moles),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .hit_num    (hit_num),
    .miss_num   (miss_num),
    .time_left  (time_left),
    .playing    (playing),
    .game_over  (game_over)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_state = MIdle;
    m_act   = '0;
    m_time  = GS;
    m_tick  = 0;
    m_sp    = 0;
    m_hit   = 0;
    m_miss  = 0;
    for (int j = 0; j < NM; j++) m_age[j] = 0;
  endtask

  // Advance the game by one clock under the given inputs.
  task automatic model_step(input bit s, input int r, input bit [NM-1:0] e);
    bit [NM-1:0] nxt;
    int          lit;
    m_hit  = 0;
    m_miss = 0;
    if (m_state != MPlay) begin
      if (s) begin
        m_state = MPlay;
        m_time  = GS;
        m_tick  = 0;
        m_sp    = 0;
      end
      return;
    end
    if (s) begin
      m_act  = '0;
      m_time = GS;
      m_tick = 0;
      m_sp   = 0;
      return;
    end
    if (m_tick == TPS - 1 && m_time == 1) begin
      m_state = MOver;
      m_time  = 0;
      m_act   = '0;
      m_tick  = 0;
      m_sp    = 0;
      return;
    end
    nxt = m_act;
    lit = $countones(m_act);
    for (int j = 0; j < NM; j++) begin
      if (m_act[j]) begin
        if (e[j]) begin
          m_hit++;
          nxt[j] = 1'b0;
        end else if (m_age[j] == LT - 1) begin
          m_miss++;
          nxt[j] = 1'b0;
        end else begin
          m_age[j]++;
        end
      end
`ifdef WHACK_PENALTY_EN
      else if (e[j]) begin
        m_miss++;
      end
`endif
    end
    if (m_sp == SP - 1 && r < NM && lit < MA) begin
      if (!m_act[r]) begin
        nxt[r]   = 1'b1;
        m_age[r] = 0;
      end
    end
    m_act = nxt;
    m_sp  = (m_sp == SP - 1) ? 0 : m_sp + 1;
    if (m_tick == TPS - 1) begin
      m_tick = 0;
      m_time--;
    end else begin
      m_tick++;
    end
  endtask

  task automatic compare_all();
    check("moles", moles, m_act);
    check("hit_num", hit_num, m_hit);
    check("miss_num", miss_num, m_miss);
    check("hit_pulse", hit_pulse, m_hit != 0);
    check("miss_pulse", miss_pulse, m_miss != 0);
    check("time_left", time_left, m_time);
    check("playing", playing, m_state == MPlay);
    check("game_over", game_over, m_state == MOver);
  endtask

  task automatic step(input bit s, input int r, input bit [NM-1:0] e);
    start      = s;
    rand_value = 5'(r);
    edge_in    = e;
    model_step(s, r, e);
    @(posedge CLOCK_50);
    #1;
    start   = 1'b0;
    edge_in = '0;
    compare_all();
  endtask

  task automatic reset_step();
    rst = 1'b1;
    model_reset();
    @(posedge CLOCK_50);
    #1;
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    bit [NM-1:0] e;
    int          r;
    int          k;

    // Reset state.
    reset_step();
    reset_step();
    check("rst_time", time_left, 3);
    check("rst_moles", moles, 0);
    check("rst_idle", {playing, game_over}, 2'b00);

    // Game 1: spawn, expiry, hit, out-of-range index, game end.
    step(1'b1, 5, '0);
    check("start_play", playing, 1);
    for (int i = 1; i <= 9; i++) step(1'b0, 5, '0);
    check("no_early_spawn", moles, 0);
    step(1'b0, 5, '0);
    check("spawn5", moles[5], 1);
    for (int i = 11; i <= 35; i++) begin
      step(1'b0, 5, '0);
      if (i == 20) check("sec_2", time_left, 2);
    end
    check("expire5_mole", moles[5], 0);
    check("expire5_pulse", miss_pulse, 1);
    check("expire5_num", miss_num, 1);
    for (int i = 36; i <= 40; i++) step(1'b0, 5, '0);
    check("respawn5", moles[5], 1);
    check("sec_1", time_left, 1);
    e = '0;
    e[5] = 1'b1;
    step(1'b0, 5, e);
    check("hit5_mole", moles[5], 0);
    check("hit5_pulse", hit_pulse, 1);
    check("hit5_num", hit_num, 1);
    for (int i = 42; i <= 49; i++) step(1'b0, 5, '0);
    step(1'b0, 20, '0);
    check("idx20_nospawn", moles, 0);
    for (int i = 51; i <= 60; i++) step(1'b0, 5, '0);
    check("over_flag", game_over, 1);
    check("over_time", time_left, 0);
    check("over_moles", moles, 0);
    check("over_nomiss", miss_pulse, 0);
    step(1'b0, 5, '1);
    check("over_edges_hit", hit_pulse, 0);
    check("over_edges_miss", miss_pulse, 0);

    // Game 2: double hit, penalty edge, active cap, silent clear at end.
    step(1'b1, 3, '0);
    check("restart_play", playing, 1);
    check("restart_time", time_left, 3);
    for (int i = 1; i <= 10; i++) step(1'b0, 3, '0);
    for (int i = 11; i <= 20; i++) step(1'b0, 7, '0);
    check("lit_3_7", moles, 18'h00088);
    e = '0;
    e[3] = 1'b1;
    e[7] = 1'b1;
    step(1'b0, 1, e);
    check("dbl_hit_num", hit_num, 2);
    check("dbl_hit_moles", moles, 0);
    e = '0;
    e[0] = 1'b1;
    step(1'b0, 1, e);
`ifdef WHACK_PENALTY_EN
    check("penalty_miss", miss_num, 1);
`else
    check("penalty_miss", miss_num, 0);
`endif
    for (int i = 23; i <= 30; i++) step(1'b0, 1, '0);
    for (int i = 31; i <= 40; i++) step(1'b0, 2, '0);
    check("lit_1_2", moles, 18'h00006);
    for (int i = 41; i <= 50; i++) step(1'b0, 9, '0);
    check("cap_blocks_9", moles[9], 0);
    for (int i = 51; i <= 59; i++) step(1'b0, 9, '0);
    check("mole2_still_lit", moles[2], 1);
    step(1'b0, 9, '0);
    check("end2_over", game_over, 1);
    check("end2_silent", miss_pulse, 0);
    check("end2_moles", moles, 0);

    // Randomized play against the model.
    step(1'b1, 0, '0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        reset_step();
      end else begin
        r = $urandom_range(0, 31);
        k = $urandom_range(0, 7);
        e = '0;
        if (k == 0) e = m_act & NM'($urandom());
        else if (k == 1) e[$urandom_range(0, NM - 1)] = 1'b1;
        step($urandom_range(0, 199) == 0, r, e);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/whack_controller.md
Name: whack_controller

Overview:
- Parametrised game controller for the switch/LED whack-a-mole game.
- Generalises the single-LED spawn/clear loop:
  - N mole channels, each with its own lifetime timeout.
  - Capped number of concurrently active moles.
  - Game-duration countdown with an IDLE/PLAY/OVER state machine.
  - Per-cycle hit/miss reporting.
- Sits between the rng, debouncer/switch_detector outputs and score_updater/display; drives LEDR.

Parameters:
- NUM_MOLES, 18, number of mole channels (LEDs/switches).
- IDX_W, 5, width of the random index input.
- SPAWN_TICKS, 50000000, clocks between spawn attempts.
- LIFE_TICKS, 100000000, clocks a mole stays lit before it expires.
- TICKS_PER_SEC, 50000000, clocks per game second.
- GAME_SECONDS, 60, game length in seconds.
- MAX_ACTIVE, 4, maximum number of simultaneously lit moles.

Ports:
- CLOCK_50  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; starts or restarts a game.
- rand_value  in  IDX_W  free-running random index.
- edge_in  in  NUM_MOLES  one-cycle switch edge pulses.
- moles  out  NUM_MOLES  lit moles (to LEDR).
- hit_pulse  out  1  at least one hit this cycle.
- miss_pulse  out  1  at least one miss this cycle.
- hit_num  out  $clog2(NUM_MOLES+1)  hits this cycle.
- miss_num  out  $clog2(NUM_MOLES+1)  misses this cycle.
- time_left  out  7  seconds remaining.
- playing  out  1  state==PLAY.
- game_over  out  1  state==OVER.

Behaviour:
- Reset:
  - State IDLE.
  - moles=0; hit_pulse, miss_pulse, hit_num, miss_num = 0.
  - time_left=GAME_SECONDS; all counters 0.
  - Reset mid-game clears every mole without generating miss events.
- Outputs are registered; events appear one cycle after the causing input/counter edge.
- IDLE:
  - start -> PLAY, with time_left=GAME_SECONDS and spawn/second counters zeroed.
- PLAY:
  - Second counter wraps at TICKS_PER_SEC-1; on wrap, time_left decrements.
  - When time_left would go 1->0: enter OVER, time_left=0, all moles cleared silently.
  - start in PLAY restarts the game: moles cleared silently, counters reloaded.
- OVER:
  - moles held 0.
  - start -> PLAY (fresh game).
  - edge_in ignored.
- Spawn (PLAY only):
  - Spawn counter wraps at SPAWN_TICKS-1; on wrap, one spawn attempt using rand_value.
  - Attempt is skipped (no retry) if any of:
    - rand_value>=NUM_MOLES;
    - the target mole is active at the start of the cycle;
    - the active count is MAX_ACTIVE.
  - A spawned mole's lifetime counter loads 0 and it lights the next cycle.
- Per mole (PLAY only):
  - Active and edge_in[j] -> cleared, counts as one hit.
  - Active and lifetime counter reaches LIFE_TICKS-1 -> cleared, counts as one miss.
  - Hit and expiry in the same cycle -> hit wins, no miss.
  - Hit on a mole being spawned in the same cycle is impossible: spawn requires the mole inactive at cycle start, and an edge on an inactive mole is not a hit.
- Reporting:
  - hit_num/miss_num = population count of that cycle's events; pulses = num!=0.
  - Multiple simultaneous hits are all counted.
- Active count never exceeds MAX_ACTIVE. MAX_ACTIVE>=NUM_MOLES means uncapped.

Optional Feature:
- WHACK_PENALTY_EN defined: in PLAY, an edge_in[j] on an inactive mole counts as one miss and is added into miss_num.
- Undefined: such edges are ignored.
- OVER/IDLE ignore all edges in both builds.

Decomposition:
- Package whack_pkg:
  - state enum {IDLE, PLAY, OVER};
  - constant-width helper for count widths;
  - shared event-count type.
- Sub-module mole_slot, generated NUM_MOLES times:
  - holds the active flag and lifetime counter;
  - inputs: spawn, whack, clear_all;
  - outputs: active, hit, expire.
- whack_controller holds the FSM, timers, spawn arbitration and popcount.

Test Plan (sim params SPAWN_TICKS=10, LIFE_TICKS=25, TICKS_PER_SEC=20, GAME_SECONDS=3, NUM_MOLES=18, MAX_ACTIVE=2):
- start pulse, rand_value=5, no edges -> moles[5] lights at spawn wrap; 25 clocks later moles[5]=0 with miss_pulse=1, miss_num=1.
- Mole 5 lit, edge_in[5] -> next cycle moles[5]=0, hit_pulse=1, hit_num=1, no later miss.
- Moles 3 and 7 lit, edge_in bits 3 and 7 in the same cycle -> hit_num=2, moles=0.
- MAX_ACTIVE reached (moles 1 and 2 lit), next spawn with rand_value=9 -> moles[9] stays 0. Separately, rand_value=20 -> no spawn.
- Run 60 clocks -> time_left steps 3,2,1; then game_over=1, moles=0, no miss events. Another start -> playing=1, time_left=3.
- With WHACK_PENALTY_EN, edge_in[0] with mole 0 inactive -> miss_num=1. Without the macro -> no event.
